data_window_nxn: RTL and testbench
==================================

DATA_WINDOW_NXN -- requirements
Module: data_window_nxn

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 512, meaning pixels per line (WIN..4096).
REQ-003 The block SHALL have parameter IMG_H, default 512, meaning lines per frame (WIN..4096).
REQ-004 The block SHALL have parameter WIN, default 7, meaning window side; it SHALL be odd, 3..9, with H=(WIN-1)/2.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port din, input, DATA_W bits, the incoming pixel in raster order.
REQ-008 The block SHALL have port in_valid, input, 1 bit; din is accepted on a clk edge where it is 1.
REQ-009 The block SHALL have port in_sof, input, 1 bit; it marks an accepted pixel as (0,0) and is qualified by in_valid.
REQ-010 The block SHALL have port win_data, output, WIN*WIN*DATA_W bits, the flattened window; element (r,c) sits at bits [(r*WIN+c+1)*DATA_W-1 -: DATA_W], with r=0 the oldest line and c=0 the oldest column.
REQ-011 The block SHALL have port win_valid, output, 1 bit, meaning win_data is a fully in-image window.
REQ-012 The block SHALL have port win_x, output, 12 bits, the window centre column.
REQ-013 The block SHALL have port win_y, output, 12 bits, the window centre row.
REQ-014 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-015 Pipeline state (x/y counters, line buffers, shift window) SHALL advance only on accepted pixels; when in_valid=0 every state element SHALL hold.
REQ-016 WIN-1 line buffers of depth IMG_W SHALL be cascaded; buffer k SHALL return the pixel accepted k*IMG_W acceptances earlier at the same column.
REQ-017 Each of the WIN rows SHALL feed a WIN-deep shift register, so the window covers columns x-WIN+1..x and rows y-WIN+1..y of the newest pixel (x,y).
REQ-018 Counter x SHALL increment per acceptance and wrap at IMG_W-1 to 0 with y+1; y SHALL wrap at IMG_H-1 to 0, so the next frame starts automatically.
REQ-019 An accepted pixel with in_sof=1 SHALL be treated as (0,0) regardless of the counters; this restarts the frame mid-stream without flushing the buffers.
REQ-020 win_valid SHALL be asserted exactly one cycle after accepting pixel (x,y) with x>=WIN-1 and y>=WIN-1, and deasserted otherwise, including on cycles without acceptance; no window spans a line wrap.
REQ-021 win_x/win_y SHALL equal (x-H, y-H) of that pixel and be registered together with win_data and win_valid (latency 1).
REQ-022 frame_done SHALL pulse one cycle after accepting (IMG_W-1, IMG_H-1); when in_sof coincides with that pixel, the pixel is (0,0) and frame_done SHALL NOT pulse.
REQ-023 Line-buffer contents from before a mid-frame in_sof are don't-care; REQ-020 gating alone SHALL guarantee that no stale window is flagged valid.

Reset
REQ-024 When rst=1 at a clk edge, x, y, win_data, win_valid, win_x, win_y and frame_done SHALL become 0; the first pixel accepted afterwards SHALL be (0,0).
REQ-025 Line-buffer RAM contents SHALL NOT require reset.
REQ-026 Reset asserted mid-frame SHALL take priority over a simultaneous in_valid, and that pixel is dropped.

Structure
REQ-027 Package data_window_pkg SHALL hold the COORD_W=12 constant, the element-index function (r,c)->bit offset, and the legal-WIN range check.
REQ-028 One sub-module, line_delay (a single-port-per-side RAM delay line of IMG_W x DATA_W with enable), SHALL be instantiated WIN-1 times via generate.
REQ-029 The shift-register window SHALL be a generate loop inside data_window_nxn; no vendor FIFO IP is used.

Verification (WIN=3, IMG_W=8, IMG_H=6, DATA_W=8, din=y*8+x)
REQ-030 Continuous ramp frame -> first win_valid one cycle after pixel 18 (2,2) with win_x=1, win_y=1, element(0,0)=0, (1,1)=9, (2,2)=18; exactly 24 win_valid pulses per frame.
REQ-031 Same frame with in_valid randomly 50% low -> identical ordered sequence of (win_x, win_y, win_data) as REQ-030, and win_valid never high on idle cycles.
REQ-032 Line wrap -> after the window centred (6,1), the next valid window is centred (1,2); win_valid stays low for pixels 24 and 25.
REQ-033 in_sof on the 21st pixel -> counters restart at (0,0); no win_valid until the 3rd row of the new frame, whose first window is at (1,1).
REQ-034 Last pixel 47 -> frame_done high for exactly one cycle; pixel 48 without in_sof is treated as (0,0) of the next frame.
REQ-035 rst=1 mid-frame while in_valid=1 -> all outputs 0 next cycle; the following frame reproduces REQ-030 exactly.

Source files
------------

// File: rtl/data_window_pkg.sv
// Shared constants and helpers for the NxN sliding-window block:
// coordinate width, flattened element offset and window-size legality.
package data_window_pkg;
    localparam int COORD_W = 12;

    // Bit offset of window element (r,c) inside the flattened window bus.
    function automatic int elem_off(input int r, input int c, input int win, input int dw);
        return (r * win + c) * dw;
    endfunction

    function automatic bit win_legal(input int win);
        return (win >= 3) && (win <= 9) && (win % 2 == 1);
    endfunction
endpackage

// File: rtl/data_window_nxn_line_delay.sv
// One line of delay: returns the pixel written DEPTH enabled cycles earlier.
// The read is asynchronous so the delayed pixel lines up with the incoming one.
module line_delay
    import data_window_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (i_en)
            r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end

    // Storage carries no reset; stale contents are masked by the window gating.
    always_ff @(posedge clk) begin
        if (i_en)
            r_mem[r_ptr] <= i_din;
    end

    assign o_dout = r_mem[r_ptr];
endmodule

// File: rtl/data_window_nxn.sv
// Raster-order pixel stream to WIN x WIN sliding window with centre coordinates.
// Line delays feed per-row shift registers; validity is gated purely by position.
module data_window_nxn
    import data_window_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int WIN    = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          din,
    input  logic                       in_valid,
    input  logic                       in_sof,
    output logic [WIN*WIN*DATA_W-1:0]  win_data,
    output logic                       win_valid,
    output logic [COORD_W-1:0]         win_x,
    output logic [COORD_W-1:0]         win_y,
    output logic                       frame_done
);
    localparam int H = (WIN - 1) / 2;

    if (!win_legal(WIN)) begin : g_bad_win
        $error("data_window_nxn: WIN must be odd and within 3..9");
    end

    logic                          w_acc;
    logic [COORD_W-1:0]            r_x, r_y;
    logic [COORD_W-1:0]            w_x, w_y;
    logic                          w_last_col, w_last_row, w_in_img;
    logic [WIN-1:0][DATA_W-1:0]    w_row;

    // Reset wins over a simultaneous pixel, which is then dropped.
    assign w_acc      = in_valid & ~rst;
    assign w_x        = in_sof ? '0 : r_x;
    assign w_y        = in_sof ? '0 : r_y;
    assign w_last_col = (w_x == COORD_W'(IMG_W - 1));
    assign w_last_row = (w_y == COORD_W'(IMG_H - 1));
    assign w_in_img   = (w_x >= COORD_W'(WIN - 1)) && (w_y >= COORD_W'(WIN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                r_x        <= w_last_col ? '0 : w_x + 1'b1;
                r_y        <= w_last_col ? (w_last_row ? '0 : w_y + 1'b1) : w_y;
                frame_done <= w_last_col && w_last_row;
                if (w_in_img) begin
                    win_valid <= 1'b1;
                    win_x     <= w_x - COORD_W'(H);
                    win_y     <= w_y - COORD_W'(H);
                end
            end
        end
    end

    // Row WIN-1 is the live line; each delay pushes the line one row older.
    assign w_row[WIN-1] = din;

    for (genvar k = 1; k < WIN; k++) begin : g_line
        line_delay #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_line (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_acc),
            .i_din  (w_row[WIN-k]),
            .o_dout (w_row[WIN-1-k])
        );
    end

    for (genvar r = 0; r < WIN; r++) begin : g_row
        logic [WIN-1:0][DATA_W-1:0] r_sr;

        always_ff @(posedge clk) begin
            if (rst)
                r_sr <= '0;
            else if (in_valid)
                r_sr <= {w_row[r], r_sr[WIN-1:1]};
        end

        for (genvar c = 0; c < WIN; c++) begin : g_col
            assign win_data[elem_off(r, c, WIN, DATA_W) +: DATA_W] = r_sr[c];
        end
    end
endmodule

// File: tb/tb_data_window_nxn.sv
// Bench for data_window_nxn: acceptance-history model of the window, random
// idle gaps, mid-frame sof, frame wrap and mid-frame reset.
module tb_data_window_nxn;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int W  = 3;
    localparam int H  = (W - 1) / 2;
    localparam int WD = W * W * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [DW-1:0]  din = '0;
    logic [WD-1:0]  win_data;
    logic           win_valid, frame_done;
    logic [11:0]    win_x, win_y;

    data_window_nxn #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: next coordinates plus the ordered history of accepted pixels.
    int            mx = 0, my = 0;
    logic [DW-1:0] hist[$];
    bit            exp_valid, exp_fd, exp_zero;
    logic [WD-1:0] exp_data;
    int            ex, ey;

    int            cnt_v, cnt_fd, n_acc, first_at;
    logic [95:0]   seq[$];
    logic [95:0]   ref_seq[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] elem(input logic [95:0] e, input int r, input int c);
        logic [WD-1:0] d;
        d = e[WD-1:0];
        return d[(r*W+c)*DW +: DW];
    endfunction

    task automatic step(input bit r, input bit v, input bit s, input logic [DW-1:0] d);
        int cx, cy;
        rst = r; in_valid = v; in_sof = s; din = d;
        @(posedge clk);
        exp_valid = 0; exp_fd = 0; exp_zero = 0;
        if (r) begin
            mx = 0; my = 0; exp_zero = 1;
        end else if (v) begin
            n_acc++;
            cx = s ? 0 : mx;
            cy = s ? 0 : my;
            hist.push_back(d);
            if (hist.size() > 64) void'(hist.pop_front());
            if (cx >= W-1 && cy >= W-1) begin
                exp_valid = 1; ex = cx - H; ey = cy - H;
                for (int rr = 0; rr < W; rr++)
                    for (int cc = 0; cc < W; cc++)
                        exp_data[(rr*W+cc)*DW +: DW] =
                            hist[hist.size() - 1 - ((W-1-rr)*IW + (W-1-cc))];
            end
            exp_fd = (cx == IW-1) && (cy == IH-1);
            mx = cx + 1; my = cy;
            if (mx == IW) begin
                mx = 0; my = cy + 1;
                if (my == IH) my = 0;
            end
        end
        #1;
        chk("win_valid", 96'(win_valid), 96'(exp_valid));
        chk("frame_done", 96'(frame_done), 96'(exp_fd));
        if (exp_zero) begin
            chk("rst_win_x", 96'(win_x), 96'(0));
            chk("rst_win_y", 96'(win_y), 96'(0));
            chk("rst_win_data", 96'(win_data), 96'(0));
        end
        if (exp_valid) begin
            chk("win_x", 96'(win_x), 96'(ex));
            chk("win_y", 96'(win_y), 96'(ey));
            chk("win_data", 96'(win_data), 96'(exp_data));
            seq.push_back({win_x, win_y, win_data});
        end
        if (win_valid && first_at < 0) first_at = n_acc;
        if (win_valid) cnt_v++;
        if (frame_done) cnt_fd++;
    endtask

    task automatic pix(input bit s, input int idle_pct, input bit rnd);
        logic [DW-1:0] d;
        for (int k = 0; k < 8 && $urandom_range(99) < idle_pct; k++)
            step(0, 0, 0, DW'($urandom));
        d = rnd ? DW'($urandom) : (s ? '0 : DW'(my*IW + mx));
        step(0, 1, s, d);
    endtask

    task automatic clr_stats();
        cnt_v = 0; cnt_fd = 0; n_acc = 0; first_at = -1;
        seq.delete();
    endtask

    task automatic frame(input int idle_pct, input bit rnd);
        for (int i = 0; i < IW*IH; i++) pix(0, idle_pct, rnd);
    endtask

    task automatic cmp_ref(input string name);
        int mism = 0;
        chk({name, "_len"}, 96'(seq.size()), 96'(ref_seq.size()));
        for (int i = 0; i < seq.size() && i < ref_seq.size(); i++)
            if (seq[i] !== ref_seq[i]) mism++;
        chk({name, "_match"}, 96'(mism), 96'(0));
    endtask

    initial begin
        clr_stats();
        step(1, 0, 0, '0);
        step(1, 1, 0, 8'h55);

        // Continuous ramp frame
        clr_stats();
        frame(0, 0);
        chk("ramp_valid_count", 96'(cnt_v), 96'(24));
        chk("ramp_fd_count", 96'(cnt_fd), 96'(1));
        chk("ramp_first_at", 96'(first_at), 96'(19));
        chk("first_x", 96'(seq[0][95:84]), 96'(1));
        chk("first_y", 96'(seq[0][83:72]), 96'(1));
        chk("first_e00", 96'(elem(seq[0], 0, 0)), 96'(0));
        chk("first_e11", 96'(elem(seq[0], 1, 1)), 96'(9));
        chk("first_e22", 96'(elem(seq[0], 2, 2)), 96'(18));
        chk("wrap_prev", 96'({seq[5][95:84], seq[5][83:72]}), 96'({12'd6, 12'd1}));
        chk("wrap_next", 96'({seq[6][95:84], seq[6][83:72]}), 96'({12'd1, 12'd2}));
        ref_seq = seq;

        // Next frame runs on without sof, with random idle cycles
        clr_stats();
        frame(50, 0);
        chk("gap_valid_count", 96'(cnt_v), 96'(24));
        chk("gap_fd_count", 96'(cnt_fd), 96'(1));
        cmp_ref("gap_seq");

        // sof on the 21st pixel of a frame
        for (int i = 0; i < 20; i++) pix(0, 25, 0);
        clr_stats();
        pix(1, 0, 0);
        for (int i = 1; i < IW*IH; i++) pix(0, 25, 0);
        chk("sof_first_at", 96'(first_at), 96'(19));
        chk("sof_first_xy", 96'({seq[0][95:84], seq[0][83:72]}), 96'({12'd1, 12'd1}));
        chk("sof_valid_count", 96'(cnt_v), 96'(24));
        chk("sof_fd_count", 96'(cnt_fd), 96'(1));

        // Random pixel values through a full frame
        clr_stats();
        frame(30, 1);
        chk("rnd_valid_count", 96'(cnt_v), 96'(24));

        // Reset mid-frame with a pixel presented, then a clean frame
        for (int i = 0; i < 30; i++) pix(0, 20, 0);
        step(1, 1, 0, 8'hAA);
        clr_stats();
        frame(0, 0);
        chk("post_rst_valid_count", 96'(cnt_v), 96'(24));
        cmp_ref("post_rst_seq");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
